// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, count-width helper and status flag bundle for sync_fifo_param.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } status_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH register array, one write port, registered read port.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  // Storage is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with fill count, almost flags and overflow/underflow pulses.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_enb,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_enb,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
  end
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  status_t       stat_q, stat_d;
  logic          rd_valid_q;
  logic          wr_ok, rd_ok;
  // Flags come from the next count so they line up with the registered count.
  always_comb begin
    wr_ok = wr_enb && !stat_q.full;
    rd_ok = rd_enb && !stat_q.empty;
    wr_ptr_d = wr_ptr_q + PW'(wr_ok);
    rd_ptr_d = rd_ptr_q + PW'(rd_ok);
    count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    stat_d.full = count_d == FULL_C;
    stat_d.empty = count_d == '0;
    stat_d.almost_full = count_d >= AF_C;
    stat_d.almost_empty = count_d <= AE_C;
    stat_d.overflow = wr_enb && stat_q.full;
    stat_d.underflow = rd_enb && stat_q.empty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_valid_q <= 1'b0;
      stat_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                  overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rd_valid_q <= rd_ok;
      stat_q <= stat_d;
    end
  end
  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk(clk),
    .rst(rst),
    .we_i(wr_ok && !rst),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .re_i(rd_ok && !rst),
    .raddr_i(rd_ptr_q),
    .rdata_o(data_out)
  );
  assign rd_valid = rd_valid_q;
  assign full = stat_q.full;
  assign empty = stat_q.empty;
  assign almost_full = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;
  assign overflow = stat_q.overflow;
  assign underflow = stat_q.underflow;
  assign count = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table, directed corner sequences and random traffic against a queue model.
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_enb = 1'b0;
  logic       rd_enb = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  typedef struct {
    logic w;
    logic r;
    logic [7:0] d;
    int cnt;
    logic emp;
    logic vld;
    logic un;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[8];

  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .data_in(data_in), .rd_enb(rd_enb),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the queue model, then compare every output 1ns after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
    int sz;
    wr_enb = w;
    rd_enb = r;
    data_in = d;
    rst = rs;
    sz = q.size();
    if (rs) begin
      q.delete();
      m_dout = '0;
      m_valid = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_ov = w && sz == 16;
      m_un = r && sz == 0;
      m_valid = r && sz != 0;
      if (m_valid) m_dout = q.pop_front();
      if (w && !m_ov) q.push_back(d);
    end
    @(posedge clk);
    #1;
    sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(sz == 16));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  initial begin
    tbl[0] = '{w: 1, r: 0, d: 8'hA1, cnt: 1, emp: 0, vld: 0, un: 0, dout: 8'h00};
    tbl[1] = '{w: 1, r: 0, d: 8'hB2, cnt: 2, emp: 0, vld: 0, un: 0, dout: 8'h00};
    tbl[2] = '{w: 0, r: 1, d: 8'h00, cnt: 1, emp: 0, vld: 1, un: 0, dout: 8'hA1};
    tbl[3] = '{w: 1, r: 1, d: 8'hC3, cnt: 1, emp: 0, vld: 1, un: 0, dout: 8'hB2};
    tbl[4] = '{w: 0, r: 1, d: 8'h00, cnt: 0, emp: 1, vld: 1, un: 0, dout: 8'hC3};
    tbl[5] = '{w: 0, r: 1, d: 8'h00, cnt: 0, emp: 1, vld: 0, un: 1, dout: 8'hC3};
    tbl[6] = '{w: 0, r: 0, d: 8'h00, cnt: 0, emp: 1, vld: 0, un: 0, dout: 8'hC3};
    tbl[7] = '{w: 1, r: 1, d: 8'hD4, cnt: 1, emp: 0, vld: 0, un: 1, dout: 8'hC3};

    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_pulses", 32'({rd_valid, overflow, underflow}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d, 0);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_underflow", i), 32'(underflow), 32'(tbl[i].un));
      chk($sformatf("tbl%0d_data_out", i), 32'(data_out), 32'(tbl[i].dout));
    end

    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'h11 + i), 0);
    chk("fill15_count", 32'(count), 32'd15);
    chk("fill15_almost_full", 32'(almost_full), 32'd1);
    chk("fill15_full", 32'(full), 32'd0);
    step(1, 0, 8'h20, 0);
    chk("fill16_full", 32'(full), 32'd1);
    step(1, 0, 8'hAA, 0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    step(0, 0, 8'h00, 0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00, 0);
      chk($sformatf("drain%0d_data", i), 32'(data_out), 32'(8'h11 + i));
      chk($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'd1);
    end
    step(0, 1, 8'h00, 0);
    chk("drain_underflow", 32'(underflow), 32'd1);
    chk("drain_hold", 32'(data_out), 32'h20);
    chk("drain_empty", 32'(empty), 32'd1);

    step(1, 1, 8'h5A, 0);
    chk("empty_rw_underflow", 32'(underflow), 32'd1);
    chk("empty_rw_count", 32'(count), 32'd1);
    step(0, 1, 8'h00, 0);
    chk("empty_rw_readback", 32'(data_out), 32'h5A);

    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h30 + i), 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'(8'h40 + i), 0);
      chk($sformatf("steady%0d_count", i), 32'(count), 32'd8);
      chk($sformatf("steady%0d_data", i), 32'(data_out), 32'(i < 8 ? 8'h30 + i : 8'h40 + i - 8));
    end

    step(1, 0, 8'h77, 0);
    chk("pre_rst_count", 32'(count), 32'd9);
    step(1, 0, 8'h78, 1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_pulses", 32'({rd_valid, overflow, underflow}), 32'd0);
    step(0, 1, 8'h00, 0);
    chk("midrst_underflow", 32'(underflow), 32'd1);

    for (int p = 0; p < 6; p++) begin
      int pw;
      pw = (p == 0) ? 90 : (p == 1) ? 10 : (p == 2) ? 50 : (p == 3) ? 75 : (p == 4) ? 25 : 55;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw + 10,
             8'($urandom), $urandom_range(0, 299) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
